// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit 7-segment display. Holds a pending and
// an active BCD value, rotates one active-low digit enable at a fixed refresh
// rate, and emits the digit code (0-9, 10 = minus, 11 = blank) for the enabled
// position. New values only take effect at the 3->0 wrap, so a frame never tears.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        negative,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  enable,
  output logic        scan_tick,
  output logic        frame_start,
  output logic        sign_ovf
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(REFRESH_DIV - 1);

  localparam logic [3:0] CodeMinus = 4'd10;
  localparam logic [3:0] CodeBlank = 4'd11;

  logic [CntW-1:0] div_cnt;
  logic [1:0]      pos;

  logic [15:0] pending_value;
  logic        pending_negative;
  logic        pending_blank_lz;
  logic        pending_valid;

  logic [15:0] active_value;
  logic        active_negative;
  logic        active_blank_lz;

  logic        tc;
  logic        wrap;
  logic [1:0]  pos_next;
  logic [15:0] src_value;
  logic        src_negative;
  logic        src_blank_lz;

  // Code for position p. "Leading" positions are p != 0 with nibbles p..3 all
  // zero; the minus takes the lowest of them.
  function automatic logic [3:0] digit_code(input logic [1:0]  p,
                                            input logic [15:0] v,
                                            input logic        neg,
                                            input logic        blz);
    logic [3:0] nib;
    logic       lead3, lead2, lead1;
    logic       is_lead, is_minus;
    nib   = v[{p, 2'b00} +: 4];
    lead3 = (v[15:12] == 4'h0);
    lead2 = lead3 && (v[11:8] == 4'h0);
    lead1 = lead2 && (v[7:4] == 4'h0);
    unique case (p)
      2'd0: begin is_lead = 1'b0;  is_minus = 1'b0;            end
      2'd1: begin is_lead = lead1; is_minus = lead1;           end
      2'd2: begin is_lead = lead2; is_minus = lead2 && !lead1; end
      2'd3: begin is_lead = lead3; is_minus = lead3 && !lead2; end
    endcase
    if (neg && is_minus) begin
      digit_code = CodeMinus;
    end else if (nib > 4'd9) begin
      digit_code = CodeBlank;
    end else if (blz && is_lead) begin
      digit_code = CodeBlank;
    end else begin
      digit_code = nib;
    end
  endfunction

  // Terminal count, wrap detection and the data the next digit is drawn from.
  always_comb begin
    tc       = (div_cnt == DivLast);
    wrap     = tc && (pos == 2'd3);
    pos_next = pos + 2'd1;
    if (wrap && pending_valid) begin
      src_value    = pending_value;
      src_negative = pending_negative;
      src_blank_lz = pending_blank_lz;
    end else begin
      src_value    = active_value;
      src_negative = active_negative;
      src_blank_lz = active_blank_lz;
    end
  end

  // Refresh divider, scan position and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      pos         <= 2'd3;
      enable      <= 4'b1111;
      digit       <= CodeBlank;
      scan_tick   <= 1'b0;
      frame_start <= 1'b0;
      sign_ovf    <= 1'b0;
    end else begin
      scan_tick   <= tc;
      frame_start <= wrap;
      if (tc) begin
        div_cnt <= '0;
        pos     <= pos_next;
        enable  <= ~(4'b0001 << pos_next);
        digit   <= digit_code(pos_next, src_value, src_negative, src_blank_lz);
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (wrap) begin
        sign_ovf <= src_negative && (src_value[15:12] != 4'h0);
      end
    end
  end

  // Pending/active value registers; a load coinciding with a wrap stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_value    <= '0;
      pending_negative <= 1'b0;
      pending_blank_lz <= 1'b1;
      pending_valid    <= 1'b0;
      active_value     <= '0;
      active_negative  <= 1'b0;
      active_blank_lz  <= 1'b1;
    end else begin
      if (wrap) begin
        active_value    <= src_value;
        active_negative <= src_negative;
        active_blank_lz <= src_blank_lz;
      end
      if (load) begin
        pending_value    <= value;
        pending_negative <= negative;
        pending_blank_lz <= blank_lz;
        pending_valid    <= 1'b1;
      end else if (wrap) begin
        pending_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-by-cycle comparison against a frame-level
// reference model, a vector table of displayed frames, and hand-written
// sequences for wrap-edge loads, double loads and mid-frame reset.
module tb_seg_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        negative;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  enable;
  logic        scan_tick;
  logic        frame_start;
  logic        sign_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: cycles since reset release, active and pending data.
  int          m_t = 0;
  logic [15:0] a_v, p_v;
  logic        a_n, a_b, p_n, p_b, p_valid;

  typedef struct {
    logic [15:0] v;
    logic        n;
    logic        b;
    int          exp_d[4];
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[6];

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .negative    (negative),
    .blank_lz    (blank_lz),
    .digit       (digit),
    .enable      (enable),
    .scan_tick   (scan_tick),
    .frame_start (frame_start),
    .sign_ovf    (sign_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s t=%0d: got %0d expected %0d", name, m_t, act, exp);
  endtask

  // Displayed code for position p, derived from the most significant non-zero nibble.
  function automatic int ref_code(input int p, input logic [15:0] v, input logic n,
                                  input logic b);
    int msd, mpos, nib;
    msd = -1;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'h0) msd = i;
    mpos = (msd < 3) ? ((msd + 1 < 1) ? 1 : msd + 1) : -1;
    nib  = int'(v[4*p +: 4]);
    if (n && p == mpos) return 10;
    if (nib > 9) return 11;
    if (b && p > msd && p != 0) return 11;
    return nib;
  endfunction

  function automatic bit is_frame_start(input int t);
    return (t >= DIV) && ((t - DIV) % (4 * DIV) == 0);
  endfunction

  task automatic check_all();
    int slot, p, off;
    if (m_t < DIV) begin
      chk("enable", int'(enable), 15);
      chk("digit", int'(digit), 11);
      chk("scan_tick", int'(scan_tick), 0);
      chk("frame_start", int'(frame_start), 0);
      chk("sign_ovf", int'(sign_ovf), 0);
    end else begin
      off  = m_t - DIV;
      slot = off / DIV;
      p    = slot % 4;
      chk("enable", int'(enable), 15 - (1 << p));
      chk("digit", int'(digit), ref_code(p, a_v, a_n, a_b));
      chk("scan_tick", int'(scan_tick), int'(off % DIV == 0));
      chk("frame_start", int'(frame_start), int'(off % (4 * DIV) == 0));
      chk("sign_ovf", int'(sign_ovf), int'(a_n && a_v[15:12] != 4'h0));
    end
  endtask

  // Advance one clock: update the model from the inputs seen at this edge, then check.
  task automatic step();
    bit   wrap;
    logic r;
    r    = rst;
    wrap = (m_t + 1 >= DIV) && ((m_t + 1 - DIV) % (4 * DIV) == 0);
    if (r) begin
      a_v = '0; a_n = 1'b0; a_b = 1'b1; p_valid = 1'b0;
    end else begin
      if (wrap && p_valid) begin
        a_v = p_v; a_n = p_n; a_b = p_b;
      end
      if (load) begin
        p_v = value; p_n = negative; p_b = blank_lz; p_valid = 1'b1;
      end else if (wrap) begin
        p_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_t = r ? 0 : m_t + 1;
    check_all();
  endtask

  task automatic load_val(input logic [15:0] v, input logic n, input logic b);
    value = v; negative = n; blank_lz = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic go_frame_start();
    int guard;
    guard = 0;
    while (!is_frame_start(m_t) && guard < 8 * DIV) begin
      step();
      guard++;
    end
  endtask

  initial begin
    tbl[0] = '{v: 16'h0042, n: 1'b1, b: 1'b1, exp_d: '{2, 4, 10, 11}, exp_ovf: 1'b0};
    tbl[1] = '{v: 16'h1234, n: 1'b1, b: 1'b1, exp_d: '{4, 3, 2, 1},   exp_ovf: 1'b1};
    tbl[2] = '{v: 16'h00A0, n: 1'b0, b: 1'b0, exp_d: '{0, 11, 0, 0},  exp_ovf: 1'b0};
    tbl[3] = '{v: 16'h0000, n: 1'b1, b: 1'b0, exp_d: '{0, 10, 0, 0},  exp_ovf: 1'b0};
    tbl[4] = '{v: 16'h0305, n: 1'b0, b: 1'b1, exp_d: '{5, 0, 3, 11},  exp_ovf: 1'b0};
    tbl[5] = '{v: 16'h0007, n: 1'b1, b: 1'b0, exp_d: '{7, 10, 0, 0},  exp_ovf: 1'b0};

    rst = 1'b1; load = 1'b0; value = '0; negative = 1'b0; blank_lz = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset release: blank until cycle DIV, then "   0" starting at pos0.
    chk("rst_enable", int'(enable), 15);
    chk("rst_digit", int'(digit), 11);
    while (m_t < DIV) step();
    chk("first_enable", int'(enable), 14);
    chk("first_digit", int'(digit), 0);
    chk("first_frame_start", int'(frame_start), 1);

    // Vector table: load mid-frame, check the whole following frame.
    for (int k = 0; k < 6; k++) begin
      go_frame_start();
      repeat (DIV + 1) step();
      load_val(tbl[k].v, tbl[k].n, tbl[k].b);
      go_frame_start();
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("tbl%0d_digit%0d", k, p), int'(digit), tbl[k].exp_d[p]);
        chk($sformatf("tbl%0d_ovf%0d", k, p), int'(sign_ovf), int'(tbl[k].exp_ovf));
        repeat (DIV) step();
      end
    end

    // Two loads in one frame: only the last one is shown.
    go_frame_start();
    step(); step();
    load_val(16'h0001, 1'b0, 1'b1);
    step(); step();
    load_val(16'h0009, 1'b0, 1'b1);
    go_frame_start();
    chk("two_loads_digit", int'(digit), 9);

    // Load on the wrap edge lands one frame later; the older pending value goes first.
    step();
    go_frame_start();
    step();
    load_val(16'h0005, 1'b0, 1'b1);
    while (!is_frame_start(m_t + 1)) step();
    load_val(16'h0006, 1'b0, 1'b1);
    chk("wrap_load_old", int'(digit), 5);
    step();
    go_frame_start();
    chk("wrap_load_new", int'(digit), 6);

    // Reset during pos2 with a pending load discards it.
    step();
    go_frame_start();
    step();
    load_val(16'h0008, 1'b0, 1'b1);
    repeat (2 * DIV - 2) step();
    chk("pre_rst_enable", int'(enable), 11);
    rst = 1'b1;
    load = 1'b1; value = 16'h0003;
    step();
    rst = 1'b0; load = 1'b0;
    chk("mid_rst_enable", int'(enable), 15);
    chk("mid_rst_digit", int'(digit), 11);
    go_frame_start();
    chk("post_rst_digit", int'(digit), 0);
    chk("post_rst_enable", int'(enable), 14);
    step();
    go_frame_start();
    chk("post_rst_discard", int'(digit), 0);

    // Randomized loads at random times, checked every cycle by the model.
    for (int k = 0; k < 60; k++) begin
      logic [15:0] rv;
      int          sh;
      repeat ($urandom_range(0, 6 * DIV)) step();
      sh = $urandom_range(0, 4);
      rv = 16'($urandom);
      rv = (sh == 4) ? 16'h0 : (rv >> (4 * sh));
      load_val(rv, 1'($urandom), 1'($urandom));
    end
    repeat (8 * DIV) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
